z80_bank_mapper: RTL

Bank-select and wait-state front end for the banked program ROM in the Z80 system. Decodes Z80 I/O writes to a single bank port, holds the current bank number, and drives the `banksel` input of the downstream banked ROM. Also produces the ROM chip enable for accesses to the banked window, stretches those accesses with a programmable number of wait states, and supports bank-port readback through the I/O space.

---
 rtl/z80_bank_mapper_if.sv | 46 ++++
 rtl/z80_bank_mapper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/z80_bank_mapper_if.sv
// Z80 bus bundles for the bank mapper: master-driven
// strobes/address/data and slave-driven readback/wait.
interface z80_master_bus;
  logic [15:0] addr;
  logic [7:0]  dmaster;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;

  modport master (
    output addr,
    output dmaster,
    output mreq_n,
    output iorq_n,
    output rd_n,
    output wr_n,
    output m1_n
  );

  modport slave (
    input addr,
    input dmaster,
    input mreq_n,
    input iorq_n,
    input rd_n,
    input wr_n,
    input m1_n
  );
endinterface

interface z80_slave_bus;
  logic [7:0] dslave;
  logic       mwait;

  modport master (
    input dslave,
    input mwait
  );

  modport slave (
    output dslave,
    output mwait
  );
endinterface

// File: rtl/z80_bank_mapper.sv
// Bank port, ROM window enable and wait-state stretcher for the banked ROM.
// Optional Z80BANK_DEFER_EN: bank switch deferred to the next M1 fetch.
module z80_bank_mapper #(
  parameter int          BANK_W      = 4,
  parameter logic [7:0]  PORT_ADDR   = 8'h1F,
  parameter int          RESET_BANK  = 0,
  parameter logic [1:0]  WIN_SEL     = 2'b01,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  z80_master_bus.slave      ibus,
  z80_slave_bus.slave       obus,
  output logic [BANK_W-1:0] banksel,
  output logic              rom_ena,
  output logic              io_hit
);

  localparam logic [BANK_W-1:0] RST_BANK =
    BANK_W'(RESET_BANK);
  localparam logic [3:0] CNT_LOAD =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        mwait_q;
  logic        port_hit;
  logic        wr_stb;
  logic        wr_q;
  logic        commit;
  logic        m1_cyc;
  logic        unused_bits;

  assign unused_bits = ^{ibus.addr, ibus.dmaster};

  // m1_n gate keeps interrupt acknowledge off the port
  assign port_hit = (ibus.addr[7:0] == PORT_ADDR)
                  && !ibus.iorq_n && ibus.m1_n;

  assign wr_stb = port_hit && !ibus.wr_n;
  assign io_hit = port_hit && !ibus.rd_n;
  assign commit = wr_stb && !wr_q;
  assign m1_cyc = !ibus.m1_n && !ibus.mreq_n;

  assign rom_ena = !ibus.mreq_n && !ibus.rd_n
                 && (ibus.addr[15:14] == WIN_SEL);

  always_comb begin
    obus.dslave = 8'h00;
    unique case (1'b1)
      io_hit:  obus.dslave = 8'(banksel);
      default: obus.dslave = 8'h00;
    endcase
  end

  assign obus.mwait = mwait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_stb;
    end
  end

`ifdef Z80BANK_DEFER_EN
  logic [BANK_W-1:0] pending;
  logic              pend_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= RST_BANK;
      pend_flag <= 1'b0;
      banksel   <= RST_BANK;
    end else begin
      if (commit) begin
        pending   <= ibus.dmaster[BANK_W-1:0];
        pend_flag <= 1'b1;
      end else if (pend_flag && m1_cyc) begin
        banksel   <= pending;
        pend_flag <= 1'b0;
      end
    end
  end
`else
  logic unused_m1;

  assign unused_m1 = m1_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      banksel <= RST_BANK;
    end else if (commit) begin
      banksel <= ibus.dmaster[BANK_W-1:0];
    end
  end
`endif

  // mwait is registered so it drops one clock after rom_ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      mwait_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (rom_ena) begin
            if (WAIT_CYCLES == 0) begin
              state <= HOLD;
            end else begin
              state   <= WAIT;
              cnt     <= CNT_LOAD;
              mwait_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (ibus.mreq_n) begin
            state   <= IDLE;
            mwait_q <= 1'b1;
          end else if (cnt == 4'd0) begin
            state   <= HOLD;
            mwait_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (ibus.mreq_n) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mwait_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
